// File: rtl/conv1_ctrl.sv
// Frame controller for the first conv layer: weight preload, pixel streaming, pipeline drain, result count check.
// Optional source-idle timeout is built in only when CONV1_CTRL_TIMEOUT_EN is defined.
module conv1_ctrl #(
    parameter int IMG_W     = 28,
    parameter int K         = 5,
    parameter int DRAIN_CYC = 3,
    parameter int TO_CYC    = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] src_data,
    input  logic       src_valid,
    output logic       src_ready,
    output logic [7:0] cnn_data_in,
    output logic       cnn_data_in_valid,
    input  logic       cnn_data_out_valid,
    output logic       w_rd_en,
    output logic [4:0] w_addr,
    output logic       busy,
    output logic       frame_done,
    output logic [9:0] out_cnt,
    output logic       cnt_err
);

    localparam int NPIX  = IMG_W * IMG_W;
    localparam int NW    = K * K;
    localparam int NOUT  = (IMG_W - K + 1) * (IMG_W - K + 1);
    localparam int PIX_W = $clog2(NPIX + 1);
    localparam int DC_W  = $clog2(DRAIN_CYC + 1);

    typedef enum logic [2:0] {IDLE, WLOAD, STREAM, DRAIN, DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [PIX_W-1:0]  r_pix;
    logic [DC_W-1:0]   r_dcnt;
    logic [4:0]        r_waddr;
    logic [9:0]        r_out;
    logic              r_cnt_err;
    logic              w_accept;
    logic              w_start_ok;
    logic              w_err_now;
    logic              w_to_hit;

    assign w_accept   = (r_state == STREAM) && src_valid;
    assign w_start_ok = (r_state == IDLE) && start;

`ifdef CONV1_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYC + 1);
    logic [TO_W-1:0] r_to;
    logic            r_to_flag;

    assign w_to_hit  = (r_state == STREAM) && !src_valid && (r_to == TO_W'(TO_CYC - 1));
    assign w_err_now = (r_out != 10'(NOUT)) || r_to_flag;

    // Consecutive idle-source cycles in STREAM; the flag marks a frame ended by timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to      <= '0;
            r_to_flag <= 1'b0;
        end else begin
            if ((r_state == STREAM) && !src_valid) begin
                r_to <= r_to + 1'b1;
            end else begin
                r_to <= '0;
            end
            if (w_start_ok) begin
                r_to_flag <= 1'b0;
            end else if (w_to_hit) begin
                r_to_flag <= 1'b1;
            end
        end
    end
`else
    assign w_to_hit  = 1'b0;
    assign w_err_now = (r_out != 10'(NOUT));
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_next = WLOAD;
                else       w_next = IDLE;
            end
            WLOAD: begin
                if (r_waddr == 5'(NW - 1)) w_next = STREAM;
                else                       w_next = WLOAD;
            end
            STREAM: begin
                if (w_accept && (r_pix == PIX_W'(NPIX - 1))) w_next = DRAIN;
                else if (w_to_hit)                           w_next = DONE;
                else                                         w_next = STREAM;
            end
            DRAIN: begin
                if (r_dcnt == DC_W'(DRAIN_CYC - 1)) w_next = DRAIN;
                else                                w_next = DRAIN;
                if (r_dcnt == DC_W'(DRAIN_CYC - 1)) w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Phase counters, result counter and sticky count-error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_waddr   <= 5'd0;
            r_dcnt    <= '0;
            r_pix     <= '0;
            r_out     <= 10'd0;
            r_cnt_err <= 1'b0;
        end else begin
            if ((r_state == WLOAD) && (w_next == WLOAD)) begin
                r_waddr <= r_waddr + 1'b1;
            end else begin
                r_waddr <= 5'd0;
            end
            if (r_state == DRAIN) begin
                r_dcnt <= r_dcnt + 1'b1;
            end else begin
                r_dcnt <= '0;
            end
            if (w_start_ok) begin
                r_pix <= '0;
            end else if (w_accept) begin
                r_pix <= r_pix + 1'b1;
            end
            // Results only count while the datapath can legitimately produce them.
            if (w_start_ok) begin
                r_out <= 10'd0;
            end else if (cnn_data_out_valid && ((r_state == STREAM) || (r_state == DRAIN))
                         && (r_out != 10'd1023)) begin
                r_out <= r_out + 1'b1;
            end
            if (w_start_ok) begin
                r_cnt_err <= 1'b0;
            end else if ((r_state == DONE) && w_err_now) begin
                r_cnt_err <= 1'b1;
            end
        end
    end

    assign src_ready         = (r_state == STREAM);
    assign cnn_data_in       = src_ready ? src_data : 8'd0;
    assign cnn_data_in_valid = src_valid && src_ready;
    assign w_rd_en           = (r_state == WLOAD);
    assign w_addr            = r_waddr;
    assign busy              = (r_state != IDLE);
    assign frame_done        = (r_state == DONE);
    assign out_cnt           = r_out;
    // Error is visible during DONE itself and stays sticky afterwards.
    assign cnt_err           = r_cnt_err || ((r_state == DONE) && w_err_now);

endmodule

// File: tb/tb_conv1_ctrl.sv
// Randomized self-checking bench for conv1_ctrl against a frame-level reference model.
module tb_conv1_ctrl;

    localparam int NPIX  = 784;
    localparam int NW    = 25;
    localparam int NOUT  = 576;
    localparam int DRAIN = 3;
    localparam int TO    = 1023;

    logic       clk = 1'b0;
    logic       rst, start, src_valid, cnn_data_out_valid;
    logic [7:0] src_data;
    logic       src_ready, cnn_data_in_valid, w_rd_en, busy, frame_done, cnt_err;
    logic [7:0] cnn_data_in;
    logic [4:0] w_addr;
    logic [9:0] out_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int m_emit;
    int m_pulses;

    conv1_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .src_data(src_data), .src_valid(src_valid),
        .src_ready(src_ready), .cnn_data_in(cnn_data_in), .cnn_data_in_valid(cnn_data_in_valid),
        .cnn_data_out_valid(cnn_data_out_valid), .w_rd_en(w_rd_en), .w_addr(w_addr),
        .busy(busy), .frame_done(frame_done), .out_cnt(out_cnt), .cnt_err(cnt_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; src_valid = 1'b1; src_data = 8'hA5; cnn_data_out_valid = 1'b1;
        tick(); tick();
        #1;
        n_checks++;
        if ({busy, src_ready, cnn_data_in_valid, w_rd_en, frame_done, cnt_err} !== 6'b0)
            $display("FAIL reset_flags got=%b exp=000000",
                     {busy, src_ready, cnn_data_in_valid, w_rd_en, frame_done, cnt_err});
        else n_pass++;
        n_checks++;
        if ({out_cnt, w_addr, cnn_data_in} !== 23'd0)
            $display("FAIL reset_values out_cnt=%0d w_addr=%0d data=%0h exp all 0", out_cnt, w_addr, cnn_data_in);
        else n_pass++;
        rst = 1'b0; src_valid = 1'b0; cnn_data_out_valid = 1'b0;
        tick();
    endtask

    // Pulses start from IDLE and walks the weight preload; ends in the first STREAM cycle.
    task automatic start_frame();
        int bad;
        m_emit = 0; m_pulses = 0; bad = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if ({out_cnt, cnt_err} !== 11'd0)
            $display("FAIL start_clear out_cnt=%0d cnt_err=%b exp 0/0", out_cnt, cnt_err);
        else n_pass++;
        for (int i = 0; i < NW; i++) begin
            cnn_data_out_valid = 1'($urandom);
            #1;
            n_checks++;
            if ({w_rd_en, src_ready, busy, w_addr} !== {1'b1, 1'b0, 1'b1, 5'(i)}) begin
                $display("FAIL wload_addr cyc=%0d rd_en=%b ready=%b w_addr=%0d exp rd_en=1 ready=0 addr=%0d",
                         i, w_rd_en, src_ready, w_addr, i);
                bad++;
            end else n_pass++;
            tick();
        end
        cnn_data_out_valid = 1'b0;
        #1;
        n_checks++;
        if ({src_ready, w_rd_en, out_cnt} !== {1'b1, 1'b0, 10'd0})
            $display("FAIL wload_end ready=%b rd_en=%b out_cnt=%0d exp 1/0/0", src_ready, w_rd_en, out_cnt);
        else n_pass++;
    endtask

    // Feeds n_pix pixels at pct% valid density, emitting up to n_strobe result strobes.
    task automatic stream_pixels(input int n_pix, input int pct, input int n_strobe);
        int acc, cyc;
        acc = 0; cyc = 0;
        while (acc < n_pix && cyc < 20000) begin
            src_valid = ($urandom_range(99) < pct) ? 1'b1 : 1'b0;
            src_data  = 8'($urandom);
            cnn_data_out_valid = (m_emit < n_strobe) && (acc > 0);
            start = (acc == 100);
            #1;
            n_checks++;
            if ({src_ready, busy, cnn_data_in_valid} !== {1'b1, 1'b1, src_valid})
                $display("FAIL stream_hs cyc=%0d ready=%b busy=%b in_valid=%b exp 1/1/%b",
                         cyc, src_ready, busy, cnn_data_in_valid, src_valid);
            else n_pass++;
            if (src_valid) begin
                n_checks++;
                if (cnn_data_in !== src_data)
                    $display("FAIL stream_data cyc=%0d got=%0h exp=%0h", cyc, cnn_data_in, src_data);
                else n_pass++;
                acc++;
            end
            if (cnn_data_in_valid) m_pulses++;
            if (cnn_data_out_valid) m_emit++;
            tick();
            cyc++;
        end
        start = 1'b0; src_valid = 1'b0; cnn_data_out_valid = 1'b0;
        n_checks++;
        if (acc != n_pix) $display("FAIL stream_timeout accepted=%0d exp=%0d", acc, n_pix);
        else n_pass++;
    endtask

    // Expects DRAIN cycles, then DONE with the model's count and error, then a quiet IDLE.
    task automatic finish_frame();
        int exp_out;
        logic exp_err;
        exp_out = (m_emit > 1023) ? 1023 : m_emit;
        exp_err = (exp_out != NOUT);
        n_checks++;
        if (m_pulses != NPIX) $display("FAIL pulse_count got=%0d exp=%0d", m_pulses, NPIX);
        else n_pass++;
        for (int d = 0; d < DRAIN; d++) begin
            src_valid = 1'b1; src_data = 8'($urandom);
            #1;
            n_checks++;
            if ({src_ready, cnn_data_in_valid, frame_done, busy, cnn_data_in} !== {4'b0001, 8'd0})
                $display("FAIL drain d=%0d ready=%b in_valid=%b done=%b busy=%b data=%0h exp 0/0/0/1/00",
                         d, src_ready, cnn_data_in_valid, frame_done, busy, cnn_data_in);
            else n_pass++;
            tick();
        end
        src_valid = 1'b0; start = 1'b1; cnn_data_out_valid = 1'b1;
        #1;
        n_checks++;
        if ({frame_done, cnt_err, out_cnt} !== {1'b1, exp_err, 10'(exp_out)})
            $display("FAIL done done=%b cnt_err=%b out_cnt=%0d exp 1/%b/%0d", frame_done, cnt_err, out_cnt, exp_err, exp_out);
        else n_pass++;
        tick();
        start = 1'b0; cnn_data_out_valid = 1'b0;
        #1;
        n_checks++;
        if ({busy, frame_done, cnt_err, out_cnt} !== {2'b00, exp_err, 10'(exp_out)})
            $display("FAIL after_done busy=%b done=%b cnt_err=%b out_cnt=%0d exp 0/0/%b/%0d",
                     busy, frame_done, cnt_err, out_cnt, exp_err, exp_out);
        else n_pass++;
        tick();
        n_checks++;
        if ({busy, out_cnt} !== {1'b0, 10'(exp_out)})
            $display("FAIL idle_hold busy=%b out_cnt=%0d exp 0/%0d", busy, out_cnt, exp_out);
        else n_pass++;
    endtask

    task automatic test_full_rate();
        start_frame(); stream_pixels(NPIX, 100, NOUT); finish_frame();
    endtask

    task automatic test_half_valid();
        start_frame(); stream_pixels(NPIX, 50, NOUT); finish_frame();
    endtask

    task automatic test_short_count();
        start_frame(); stream_pixels(NPIX, 70, NOUT - 1); finish_frame();
    endtask

    task automatic test_saturate();
        start_frame(); stream_pixels(NPIX, 30, 1100); finish_frame();
    endtask

    task automatic test_abort();
        start_frame();
        stream_pixels(400, 60, 100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({busy, src_ready, frame_done, cnt_err, out_cnt} !== 14'd0)
            $display("FAIL abort busy=%b ready=%b done=%b err=%b out_cnt=%0d exp all 0",
                     busy, src_ready, frame_done, cnt_err, out_cnt);
        else n_pass++;
        tick();
        n_checks++;
        if (busy !== 1'b0) $display("FAIL abort_idle busy=%b exp 0", busy);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int bad;
        bad = 0;
        start_frame();
        stream_pixels(200, 100, 0);
`ifdef CONV1_CTRL_TIMEOUT_EN
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            if (frame_done !== 1'b0 || busy !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL timeout_early bad_cycles=%0d exp 0", bad);
        else n_pass++;
        tick();
        n_checks++;
        if ({frame_done, cnt_err} !== 2'b11)
            $display("FAIL timeout_done done=%b cnt_err=%b exp 1/1", frame_done, cnt_err);
        else n_pass++;
        tick();
        n_checks++;
        if ({busy, cnt_err} !== 2'b01) $display("FAIL timeout_idle busy=%b cnt_err=%b exp 0/1", busy, cnt_err);
        else n_pass++;
`else
        for (int i = 0; i < TO + 80; i++) begin
            tick();
            if (busy !== 1'b1 || src_ready !== 1'b1 || frame_done !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL no_timeout bad_cycles=%0d exp 0", bad);
        else n_pass++;
        stream_pixels(NPIX - 200, 100, 0);
        m_pulses = NPIX;
        finish_frame();
`endif
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_half_valid();
        test_short_count();
        test_saturate();
        test_abort();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
